// File: rtl/xcvr_dir_ctrl.sv
// Break-before-make sequencer for the dir/nOE pins of one 74245 transceiver.
// Disables, changes dir, re-enables, with programmable dead time on each step.
module xcvr_dir_ctrl #(
    parameter int OFF_CYC = 2,
    parameter int DIR_CYC = 1,
    parameter int ON_CYC  = 2,
    parameter bit LOG     = 1'b0,
    parameter     NAME    = "xcvr_dir_ctrl"
) (
    input  logic clk,
    input  logic _reset,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_en,
    input  logic cmd_dir,
    output logic dir,
    output logic nOE,
    output logic settled,
    output logic busy
);

    localparam int MAX_A   = (OFF_CYC > DIR_CYC) ? OFF_CYC : DIR_CYC;
    localparam int MAX_CYC = (MAX_A > ON_CYC) ? MAX_A : ON_CYC;
    localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] OFF_LD = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] DIR_LD = CW'(DIR_CYC - 1);
    localparam logic [CW-1:0] ON_LD  = CW'(ON_CYC - 1);

    if (OFF_CYC < 1 || DIR_CYC < 1 || ON_CYC < 1) begin : g_bad_param
        $error("xcvr_dir_ctrl: OFF_CYC, DIR_CYC and ON_CYC must all be >= 1");
    end

    typedef enum logic [2:0] {ST_OFF, ST_DRAIN, ST_DIRSET, ST_ENWAIT, ST_ON} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          noe_q, noe_d;
    logic          settled_q, settled_d;
    logic          ready_q, ready_d;
    logic          tgt_en_q, tgt_en_d;
    logic          tgt_dir_q, tgt_dir_d;
    logic          accept;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            dir_q     <= 1'b1;
            noe_q     <= 1'b1;
            settled_q <= 1'b0;
            ready_q   <= 1'b1;
            tgt_en_q  <= 1'b0;
            tgt_dir_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            noe_q     <= noe_d;
            settled_q <= settled_d;
            ready_q   <= ready_d;
            tgt_en_q  <= tgt_en_d;
            tgt_dir_q <= tgt_dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        tgt_en_d  = tgt_en_q;
        tgt_dir_d = tgt_dir_q;
        accept    = cmd_valid && ready_q;

        unique case (state_q)
            ST_OFF: begin
                if (accept) begin
                    tgt_en_d  = cmd_en;
                    tgt_dir_d = cmd_dir;
                    if (cmd_en) begin
                        if (cmd_dir == dir_q) begin
                            state_d = ST_ENWAIT;
                            cnt_d   = ON_LD;
                        end else begin
                            state_d = ST_DIRSET;
                            dir_d   = cmd_dir;
                            cnt_d   = DIR_LD;
                        end
                    end
                end
            end
            ST_ON: begin
                if (accept) begin
                    tgt_en_d  = cmd_en;
                    tgt_dir_d = cmd_dir;
                    if (!(cmd_en && cmd_dir == dir_q)) begin
                        state_d = ST_DRAIN;
                        cnt_d   = OFF_LD;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!tgt_en_q) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (tgt_dir_q != dir_q) begin
                    state_d = ST_DIRSET;
                    dir_d   = tgt_dir_q;
                    cnt_d   = DIR_LD;
                end else begin
                    state_d = ST_ENWAIT;
                    cnt_d   = ON_LD;
                end
            end
            ST_DIRSET: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_ENWAIT;
                    cnt_d   = ON_LD;
                end
            end
            ST_ENWAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Pin levels follow the state being entered so every output is a flop.
        noe_d     = !(state_d == ST_ENWAIT || state_d == ST_ON);
        settled_d = (state_d == ST_ON);
        ready_d   = (state_d == ST_OFF || state_d == ST_ON);
    end

    assign dir       = dir_q;
    assign nOE       = noe_q;
    assign settled   = settled_q;
    assign cmd_ready = ready_q;
    assign busy      = !ready_q;

`ifndef SYNTHESIS
    int gap_q;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            gap_q <= DIR_CYC;
        end else begin
            assert (!(settled_q && noe_q))
                else $error("%s: settled while nOE high", NAME);
            if (dir_d != dir_q) begin
                assert (noe_q && noe_d)
                    else $error("%s: dir changed while nOE low", NAME);
                gap_q <= 0;
            end else if (gap_q < DIR_CYC) begin
                gap_q <= gap_q + 1;
            end
            if (noe_q && !noe_d) begin
                assert (gap_q + 1 >= DIR_CYC)
                    else $error("%s: nOE fell too soon after dir change", NAME);
            end
        end
    end

    if (LOG) begin : g_log
        always @(posedge clk) begin
            if (_reset && state_d != state_q)
                $display("%s: %s -> %s", NAME, state_q.name(), state_d.name());
        end
    end
`endif

endmodule

// File: tb/tb_xcvr_dir_ctrl.sv
// Directed bench for xcvr_dir_ctrl: a vector table for the default instance
// plus hand sequences for async reset and a non-default timing instance.
module tb_xcvr_dir_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid, cmd_en, cmd_dir;
    logic cmd_ready, dir, noe, settled, busy;
    logic p_valid, p_en, p_dir;
    logic p_ready, p_dir_o, p_noe, p_settled, p_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xcvr_dir_ctrl dut (
        .clk       (clk),
        ._reset    (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_en    (cmd_en),
        .cmd_dir   (cmd_dir),
        .dir       (dir),
        .nOE       (noe),
        .settled   (settled),
        .busy      (busy)
    );

    xcvr_dir_ctrl #(.OFF_CYC(3), .DIR_CYC(2), .ON_CYC(4), .NAME("p2")) dut_p2 (
        .clk       (clk),
        ._reset    (rst_n),
        .cmd_valid (p_valid),
        .cmd_ready (p_ready),
        .cmd_en    (p_en),
        .cmd_dir   (p_dir),
        .dir       (p_dir_o),
        .nOE       (p_noe),
        .settled   (p_settled),
        .busy      (p_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic v, en, d_in;
        logic rdy, d, n, s;
    } vec_t;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    vec_t vecs [29];

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int t_dir, t_noe, t_set;

        // inputs {valid,en,dir}, expected after the edge {ready,dir,nOE,settled}
        vecs[0]  = '{H,H,H, L,H,L,L};  // OFF same dir -> ENWAIT
        vecs[1]  = '{L,L,L, L,H,L,L};
        vecs[2]  = '{L,L,L, H,H,L,H};  // ON
        vecs[3]  = '{H,H,H, H,H,L,H};  // same-dir no-op
        vecs[4]  = '{H,H,L, L,H,H,L};  // turnaround accept, edge 0
        vecs[5]  = '{H,H,H, L,H,H,L};  // held while busy, ignored
        vecs[6]  = '{L,L,L, L,L,H,L};  // edge 2 dir flips
        vecs[7]  = '{L,L,L, L,L,L,L};  // edge 3 nOE low
        vecs[8]  = '{L,L,L, L,L,L,L};
        vecs[9]  = '{L,L,L, H,L,L,H};  // edge 5 settled
        vecs[10] = '{H,L,L, L,L,H,L};  // release
        vecs[11] = '{L,L,L, L,L,H,L};
        vecs[12] = '{L,L,L, H,L,H,L};  // OFF
        vecs[13] = '{H,L,H, H,L,H,L};  // OFF en=0 no-op
        vecs[14] = '{H,H,H, L,H,H,L};  // OFF dir change -> DIRSET
        vecs[15] = '{L,L,L, L,H,L,L};
        vecs[16] = '{L,L,L, L,H,L,L};
        vecs[17] = '{L,L,L, H,H,L,H};
        vecs[18] = '{H,H,L, L,H,H,L};  // backpressure: valid held throughout
        vecs[19] = '{H,H,H, L,H,H,L};
        vecs[20] = '{H,H,L, L,L,H,L};
        vecs[21] = '{H,L,H, L,L,L,L};
        vecs[22] = '{H,H,H, L,L,L,L};
        vecs[23] = '{H,H,L, H,L,L,H};
        vecs[24] = '{H,H,L, H,L,L,H};  // value present at accept edge used
        vecs[25] = '{H,H,H, L,L,H,L};
        vecs[26] = '{L,L,L, L,L,H,L};
        vecs[27] = '{L,L,L, L,H,H,L};
        vecs[28] = '{L,L,L, L,H,L,L};  // ENWAIT

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_en = 1'b0; cmd_dir = 1'b0;
        p_valid = 1'b0; p_en = 1'b0; p_dir = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset nOE", noe, 1);
        check("reset dir", dir, 1);
        check("reset settled", settled, 0);
        check("reset ready", cmd_ready, 1);
        check("reset busy", busy, 0);
        check("reset p2 nOE", p_noe, 1);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            cmd_valid = vecs[i].v;
            cmd_en    = vecs[i].en;
            cmd_dir   = vecs[i].d_in;
            step();
            check($sformatf("vec%0d ready", i), cmd_ready, vecs[i].rdy);
            check($sformatf("vec%0d busy", i), busy, !vecs[i].rdy);
            check($sformatf("vec%0d dir", i), dir, vecs[i].d);
            check($sformatf("vec%0d nOE", i), noe, vecs[i].n);
            check($sformatf("vec%0d settled", i), settled, vecs[i].s);
        end
        cmd_valid = 1'b0;

        // Async reset mid-ENWAIT, well away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst nOE", noe, 1);
        check("async rst dir", dir, 1);
        check("async rst ready", cmd_ready, 1);
        check("async rst settled", settled, 0);
        repeat (2) @(posedge clk);
        #1;
        check("held rst nOE", noe, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post rst nOE", noe, 1);
        check("post rst ready", cmd_ready, 1);
        check("post rst settled", settled, 0);

        cmd_valid = 1'b1; cmd_en = 1'b1; cmd_dir = 1'b0;
        step();
        cmd_valid = 1'b0;
        check("post rst dirset dir", dir, 0);
        check("post rst dirset nOE", noe, 1);
        check("post rst dirset ready", cmd_ready, 0);
        step();
        check("post rst enwait nOE", noe, 0);
        step();
        step();
        check("post rst settled latency", settled, 1);

        // Non-default timing instance
        p_valid = 1'b1; p_en = 1'b1; p_dir = 1'b1;
        step();
        p_valid = 1'b0;
        check("p2 enable nOE", p_noe, 0);
        check("p2 enable dir", p_dir_o, 1);
        k = 0;
        while (!p_settled && k < 20) begin
            step();
            k++;
        end
        check("p2 enable latency", k, 4);

        p_valid = 1'b1; p_en = 1'b1; p_dir = 1'b0;
        step();
        p_valid = 1'b0;
        check("p2 turn nOE edge0", p_noe, 1);
        t_dir = 0; t_noe = 0; t_set = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (t_dir == 0 && p_dir_o == 1'b0) t_dir = e;
            if (t_noe == 0 && p_noe == 1'b0) t_noe = e;
            if (t_set == 0 && p_settled == 1'b1) t_set = e;
        end
        check("p2 turn dir edge", t_dir, 3);
        check("p2 turn nOE edge", t_noe, 5);
        check("p2 turn settled edge", t_set, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xcvr_dir_ctrl.md
Name: xcvr_dir_ctrl

Overview:
Sequencer that drives the dir and nOE pins of one hct74245 bus transceiver from CPU-side transfer commands. It enforces break-before-make turnaround: the transceiver is disabled, then dir changes, then it is re-enabled, with dead time on every step. This prevents bus contention and guarantees the device's PD_OE / PD_DIR / PD_TRANS propagation windows before the bus is reported stable. It sits between control decode and each 74245 on a bidirectional bus segment.

Parameters:
OFF_CYC, 2, clocks nOE is held high after disable before dir may change (covers the disable propagation delay); must be >= 1.
DIR_CYC, 1, clocks after a dir change before nOE may go low; must be >= 1.
ON_CYC, 2, clocks after nOE goes low before settled asserts (covers PD_OE/PD_DIR); must be >= 1.
LOG, 0, when 1, $display every state transition with NAME.
NAME, "xcvr_dir_ctrl", instance label for logging.

Ports:
clk  in  1  rising-edge clock
_reset  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready
cmd_en  in  1  1 = drive the bus, 0 = release it (tristate)
cmd_dir  in  1  1 = A->B, 0 = B->A (same encoding as the 74245 dir pin)
dir  out  1  to 74245 dir
nOE  out  1  to 74245 nOE, active low
settled  out  1  transceiver enabled and past ON_CYC; data valid on the far side
busy  out  1  sequence in progress (= !cmd_ready)

Behaviour:
- States: OFF, DRAIN, DIRSET, ENWAIT, ON. A down-counter is sized $clog2(max param + 1) bits. Elaboration fails if any *_CYC parameter is < 1.
- Reset (async, takes effect without a clock edge): state=OFF, nOE=1, dir=1, settled=0, cmd_ready=1, counter=0.
- cmd_ready=1 only in OFF and ON. cmd_en and cmd_dir are latched into target registers on the accept edge only. Holding cmd_valid while not ready has no effect.
- OFF, accept:
  - cmd_en=0 -> stay OFF (no-op).
  - cmd_en=1 and cmd_dir==dir -> ENWAIT.
  - cmd_en=1 and cmd_dir!=dir -> DIRSET.
- ON, accept:
  - cmd_en=1 and cmd_dir==dir -> stay ON; settled stays 1; zero-latency no-op.
  - otherwise -> DRAIN.
- DRAIN: nOE=1 from the accept edge; lasts OFF_CYC clocks. Exit:
  - target en=0 -> OFF.
  - target dir!=dir -> DIRSET.
  - else -> ENWAIT.
- DIRSET: dir takes the target value on entry; nOE=1; lasts DIR_CYC clocks, then -> ENWAIT.
- ENWAIT: nOE=0 on entry; settled=0; lasts ON_CYC clocks, then -> ON.
- ON: nOE=0, settled=1, cmd_ready=1.
- All outputs are registered; no combinational path from cmd_* to dir/nOE.
- Invariants (assert in sim):
  - dir never changes while nOE=0.
  - nOE never falls fewer than DIR_CYC clocks after a dir change.
  - settled=1 implies nOE=0.
- Timing with defaults, ON(dir=1) -> cmd(en=1, dir=0) accepted at edge 0:
  - nOE=1 after edge 0.
  - dir=0 after edge 2.
  - nOE=0 after edge 3.
  - settled=1 and cmd_ready=1 after edge 5.
  - Total latency = OFF_CYC+DIR_CYC+ON_CYC.
- Timing from OFF with a dir change: latency DIR_CYC+ON_CYC. Same dir: ON_CYC.
- Reset asserted mid-sequence: nOE goes to 1 immediately and asynchronously; the latched command is discarded. After release, the block is in OFF with cmd_ready=1 on the first clock.
- Reset release is synchronous-safe: the first state change occurs no earlier than the first rising edge after _reset goes high.

Test Plan:
- Reset check: hold _reset=0 and toggle clk -> nOE=1, dir=1, settled=0, cmd_ready=1. Assert _reset=0 mid-ENWAIT -> nOE=1 within 1ns, with no clock edge.
- OFF enable, same dir: cmd(en=1, dir=1) -> nOE=0 after 1 edge; settled=1 after 2 edges; dir stays 1 throughout.
- ON(A->B) to B->A, defaults: nOE=1 at +0, dir=0 at +2, nOE=0 at +3, settled=1 at +5. With an attached hct74245 and Vb=8'b10101010, A===8'b10101010 once settled and never X or contended before that.
- ON, same-dir no-op: cmd(en=1, dir=1) while ON(dir=1) -> accepted the same cycle; nOE, dir and settled unchanged; busy never asserts.
- Release: ON -> cmd(en=0) -> nOE=1 after edge 0; state OFF and cmd_ready=1 after OFF_CYC=2 edges; dir unchanged; the transceiver's A/B go 8'bzzzzzzzz when not externally driven.
- Backpressure and parameters: hold cmd_valid during DRAIN with changing cmd_dir -> ignored until ready, then the value present at the accept edge is used. Rerun the turnaround case with OFF_CYC=3, DIR_CYC=2, ON_CYC=4 -> settled at +9.
